// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_hazard_scoreboard                                         |
// | Description : Decode-stage forwarding select and hazard detection. Tracks  |
// |               FWD_STAGES shadow slots of in-pipe writers plus a per-       |
// |               register counter of outstanding long-latency writes.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int REGID_W     = 5,
  parameter int NUM_SRC     = 2,
  parameter int FWD_STAGES  = 3,
  parameter int STG_W       = 2,
  parameter int PEND_W      = 2,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       advance,
  input  logic                       issue_valid,
  input  logic                       issue_reg_write,
  input  logic [REGID_W-1:0]         issue_regid,
  input  logic [STG_W-1:0]           issue_rdy_stage,
  input  logic                       issue_long,
  input  logic [NUM_SRC-1:0]         src_read,
  input  logic [NUM_SRC*REGID_W-1:0] src_regid,
  input  logic                       lat_done,
  input  logic [REGID_W-1:0]         lat_regid,
  output logic [NUM_SRC-1:0]         src_fwd_hit,
  output logic [NUM_SRC*STG_W-1:0]   src_fwd_stage,
  output logic                       hazard_stall,
  output logic                       sb_error
);

  localparam logic [PEND_W-1:0] c_cnt_max = '1;

  // Shadow slots: slot 0 is the youngest (EX), higher indices are older.
  logic [FWD_STAGES-1:0] r_slot_valid;
  logic [REGID_W-1:0]    r_slot_regid [FWD_STAGES];
  logic [STG_W-1:0]      r_slot_rdy   [FWD_STAGES];

  // Per-register counter status, flattened so they can be indexed by id.
  logic [NUM_REGS-1:0] w_cnt_nz;
  logic [NUM_REGS-1:0] w_cnt_full;
  logic [NUM_REGS-1:0] w_cnt_err;

  logic [NUM_SRC-1:0]  w_src_stall;
  logic                w_waw_stall;
  logic                w_ovf_stall;
  logic                w_accept;
  logic                w_qualify;
  logic                w_inc_any;
  logic                w_dec_any;
  logic                r_sb_error;

  // Per-source match: youngest matching slot wins; an unready winner stalls.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [REGID_W-1:0] w_id;
    logic               w_rd;
    logic               w_hit;
    logic [STG_W-1:0]   w_sel;
    logic               w_not_rdy;

    assign w_id = src_regid[s*REGID_W +: REGID_W];
    assign w_rd = src_read[s] && (w_id != '0);

    // Scan oldest to youngest so the last (youngest) match overrides.
    always_comb begin
      w_hit     = 1'b0;
      w_sel     = '0;
      w_not_rdy = 1'b0;
      for (int i = FWD_STAGES - 1; i >= 0; i--) begin
        if (w_rd && r_slot_valid[i] && (r_slot_regid[i] == w_id)) begin
          w_hit     = 1'b1;
          w_sel     = STG_W'(i);
          w_not_rdy = (r_slot_rdy[i] > STG_W'(i));
        end
      end
    end

    assign src_fwd_hit[s]                  = w_hit;
    assign src_fwd_stage[s*STG_W +: STG_W] = w_sel;
    assign w_src_stall[s]                  = w_not_rdy | (w_rd & w_cnt_nz[w_id]);
  end

  // A new writer must not overtake an older in-pipe writer that is not yet ready.
  always_comb begin
    w_waw_stall = 1'b0;
    for (int i = 0; i < FWD_STAGES; i++) begin
      if (issue_reg_write && r_slot_valid[i] && (r_slot_regid[i] == issue_regid)
          && (r_slot_rdy[i] != '0)) begin
        w_waw_stall = 1'b1;
      end
    end
  end

  assign w_ovf_stall  = issue_long & issue_reg_write & w_cnt_full[issue_regid];
  assign hazard_stall = (|w_src_stall) | w_waw_stall | w_ovf_stall;

  assign w_accept  = issue_valid & advance & ~hazard_stall & ~flush;
  assign w_qualify = issue_reg_write & (issue_regid != '0) & ~issue_long;
  assign w_inc_any = w_accept & issue_long & issue_reg_write & (issue_regid != '0);
  assign w_dec_any = lat_done & (lat_regid != '0);

  // Slot pipeline: shift on advance, then flush kills the youngest slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= '0;
      for (int i = 0; i < FWD_STAGES; i++) begin
        r_slot_regid[i] <= '0;
        r_slot_rdy[i]   <= '0;
      end
    end else begin
      if (advance) begin
        for (int i = 1; i < FWD_STAGES; i++) begin
          r_slot_valid[i] <= r_slot_valid[i-1];
          r_slot_regid[i] <= r_slot_regid[i-1];
          r_slot_rdy[i]   <= r_slot_rdy[i-1];
        end
        r_slot_valid[0] <= w_accept & w_qualify;
        r_slot_regid[0] <= issue_regid;
        r_slot_rdy[0]   <= issue_rdy_stage;
      end
      if (flush) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          r_slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Outstanding long-op counters; x0 is never tracked.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign w_cnt_nz[r]   = 1'b0;
      assign w_cnt_full[r] = 1'b0;
      assign w_cnt_err[r]  = 1'b0;
    end else begin : g_live
      logic [PEND_W-1:0] r_cnt;
      logic              w_inc;
      logic              w_dec;

      assign w_inc = w_inc_any & (issue_regid == REGID_W'(r));
      assign w_dec = w_dec_any & (lat_regid == REGID_W'(r));

      // Simultaneous inc and dec cancel; underflow and overflow saturate.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec) begin
          if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
      end

      assign w_cnt_nz[r]   = (r_cnt != '0);
      assign w_cnt_full[r] = (r_cnt == c_cnt_max);
      assign w_cnt_err[r]  = (w_dec & ~w_inc & (r_cnt == '0))
                           | (w_inc & ~w_dec & (r_cnt == c_cnt_max));
    end
  end

  // Sticky error flag for counter misuse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_error <= 1'b0;
    end else if (|w_cnt_err) begin
      r_sb_error <= 1'b1;
    end
  end

  assign sb_error = r_sb_error;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_id_hazard_scoreboard                                      |
// | Description : Directed self-checking bench for id_hazard_scoreboard.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_id_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       advance;
  logic       issue_valid;
  logic       issue_reg_write;
  logic [4:0] issue_regid;
  logic [1:0] issue_rdy_stage;
  logic       issue_long;
  logic [1:0] src_read;
  logic [9:0] src_regid;
  logic       lat_done;
  logic [4:0] lat_regid;
  logic [1:0] src_fwd_hit;
  logic [3:0] src_fwd_stage;
  logic       hazard_stall;
  logic       sb_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .advance         (advance),
    .issue_valid     (issue_valid),
    .issue_reg_write (issue_reg_write),
    .issue_regid     (issue_regid),
    .issue_rdy_stage (issue_rdy_stage),
    .issue_long      (issue_long),
    .src_read        (src_read),
    .src_regid       (src_regid),
    .lat_done        (lat_done),
    .lat_regid       (lat_regid),
    .src_fwd_hit     (src_fwd_hit),
    .src_fwd_stage   (src_fwd_stage),
    .hazard_stall    (hazard_stall),
    .sb_error        (sb_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush           = 1'b0;
    advance         = 1'b1;
    issue_valid     = 1'b0;
    issue_reg_write = 1'b0;
    issue_regid     = 5'd0;
    issue_rdy_stage = 2'd0;
    issue_long      = 1'b0;
    src_read        = 2'b00;
    src_regid       = 10'd0;
    lat_done        = 1'b0;
    lat_regid       = 5'd0;
  endtask

  task automatic issue(input logic [4:0] id, input logic [1:0] rdy, input logic lng);
    issue_valid     = 1'b1;
    issue_reg_write = 1'b1;
    issue_regid     = id;
    issue_rdy_stage = rdy;
    issue_long      = lng;
  endtask

  task automatic srcs(input logic [1:0] rd, input logic [4:0] a, input logic [4:0] b);
    src_read  = rd;
    src_regid = {b, a};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    check("rst_hit",   32'(src_fwd_hit),   32'h0);
    check("rst_stage", 32'(src_fwd_stage), 32'h0);
    check("rst_stall", 32'(hazard_stall),  32'h0);
    check("rst_err",   32'(sb_error),      32'h0);
    rst = 1'b0;
    next_cycle();

    // ALU x5 then consumers as it ages through the slots
    issue(5'd5, 2'd0, 1'b0); #1;
    check("alu_issue_stall", 32'(hazard_stall), 32'h0);
    next_cycle();
    idle(); srcs(2'b01, 5'd5, 5'd0); #1;
    check("alu_hit_s0",   32'(src_fwd_hit),   32'h1);
    check("alu_stage_s0", 32'(src_fwd_stage), 32'h0);
    check("alu_stall_s0", 32'(hazard_stall),  32'h0);
    next_cycle();
    check("alu_stage_s1", 32'(src_fwd_stage), 32'h1);
    next_cycle();
    check("alu_stage_s2", 32'(src_fwd_stage), 32'h2);
    next_cycle();
    check("alu_aged_out", 32'(src_fwd_hit),   32'h0);

    // load x7, consumer on src1 stalls one cycle then forwards from slot 1
    idle(); issue(5'd7, 2'd1, 1'b0); #1;
    check("ld_issue_stall", 32'(hazard_stall), 32'h0);
    next_cycle();
    idle(); issue_valid = 1'b1; srcs(2'b10, 5'd0, 5'd7); #1;
    check("ld_use_stall", 32'(hazard_stall),  32'h1);
    check("ld_use_hit",   32'(src_fwd_hit),   32'h2);
    check("ld_use_stage", 32'(src_fwd_stage), 32'h0);
    next_cycle();
    check("ld_after_stall", 32'(hazard_stall),  32'h0);
    check("ld_after_hit",   32'(src_fwd_hit),   32'h2);
    check("ld_after_stage", 32'(src_fwd_stage), 32'h4);
    next_cycle();

    // x3 in slot 0 and slot 2, x8 in slot 1
    idle(); issue(5'd3, 2'd0, 1'b0); next_cycle();
    issue(5'd8, 2'd0, 1'b0); next_cycle();
    issue(5'd3, 2'd0, 1'b0); next_cycle();
    idle(); advance = 1'b0; srcs(2'b11, 5'd3, 5'd0); #1;
    check("youngest_hit",   32'(src_fwd_hit),   32'h1);
    check("youngest_stage", 32'(src_fwd_stage), 32'h0);
    next_cycle();
    srcs(2'b11, 5'd3, 5'd8); #1;
    check("hold_hit",   32'(src_fwd_hit),   32'h3);
    check("hold_stage", 32'(src_fwd_stage), 32'h4);
    advance = 1'b1; issue(5'd0, 2'd0, 1'b0);
    next_cycle();
    idle(); srcs(2'b11, 5'd0, 5'd3); #1;
    check("x0_hit",   32'(src_fwd_hit),   32'h2);
    check("x0_stage", 32'(src_fwd_stage), 32'h4);

    // long op x9: stall until completion, inc+dec same cycle keeps count
    idle(); issue(5'd9, 2'd0, 1'b1); #1;
    check("long_issue_stall", 32'(hazard_stall), 32'h0);
    next_cycle();
    idle(); srcs(2'b01, 5'd9, 5'd0); #1;
    check("long_use_stall", 32'(hazard_stall), 32'h1);
    check("long_use_hit",   32'(src_fwd_hit),  32'h0);
    next_cycle();
    check("long_still_stall", 32'(hazard_stall), 32'h1);
    idle(); issue(5'd9, 2'd0, 1'b1); lat_done = 1'b1; lat_regid = 5'd9; #1;
    check("incdec_issue_ok", 32'(hazard_stall), 32'h0);
    next_cycle();
    idle(); srcs(2'b01, 5'd9, 5'd0); #1;
    check("incdec_keeps", 32'(hazard_stall), 32'h1);
    lat_done = 1'b1; lat_regid = 5'd9;
    next_cycle();
    lat_done = 1'b0; #1;
    check("long_drained", 32'(hazard_stall), 32'h0);
    check("long_no_err",  32'(sb_error),     32'h0);

    // overflow guard at all-ones count on x10
    idle(); issue(5'd10, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) next_cycle();
    check("ovf_guard", 32'(hazard_stall), 32'h1);
    idle(); #1;
    check("ovf_guard_off", 32'(hazard_stall), 32'h0);
    lat_done = 1'b1; lat_regid = 5'd10;
    for (int k = 0; k < 3; k++) next_cycle();
    idle(); srcs(2'b01, 5'd10, 5'd0); #1;
    check("ovf_drained", 32'(hazard_stall), 32'h0);
    check("ovf_no_err",  32'(sb_error),     32'h0);

    // lat_done on x0 ignored, on idle x4 sets sticky error
    idle(); lat_done = 1'b1; lat_regid = 5'd0;
    next_cycle();
    check("x0_done_ignored", 32'(sb_error), 32'h0);
    lat_regid = 5'd4;
    next_cycle();
    idle(); #1;
    check("underflow_err", 32'(sb_error), 32'h1);
    next_cycle(); next_cycle();
    check("err_sticky", 32'(sb_error), 32'h1);

    // flush kills slot 0, keeps older slot and long-op counters
    idle(); issue(5'd12, 2'd0, 1'b1); next_cycle();
    issue(5'd6, 2'd0, 1'b0); next_cycle();
    issue(5'd11, 2'd0, 1'b0); flush = 1'b1; next_cycle();
    idle(); srcs(2'b11, 5'd6, 5'd11); #1;
    check("flush_hit",   32'(src_fwd_hit),   32'h1);
    check("flush_stage", 32'(src_fwd_stage), 32'h1);
    srcs(2'b01, 5'd12, 5'd0); #1;
    check("flush_cnt_kept", 32'(hazard_stall), 32'h1);
    lat_done = 1'b1; lat_regid = 5'd12;
    next_cycle();
    lat_done = 1'b0; #1;
    check("flush_cnt_drain", 32'(hazard_stall), 32'h0);

    // asynchronous reset between edges
    idle(); issue(5'd5, 2'd0, 1'b0); next_cycle();
    idle(); srcs(2'b01, 5'd5, 5'd0); #1;
    check("pre_arst_hit", 32'(src_fwd_hit), 32'h1);
    #1 rst = 1'b1; #1;
    check("arst_hit", 32'(src_fwd_hit), 32'h0);
    check("arst_err", 32'(sb_error),    32'h0);
    #1 rst = 1'b0;
    next_cycle();
    check("post_arst_hit", 32'(src_fwd_hit), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
